test_fast_dram_axi_rd_buffer: RTL and testbench
===============================================

// Module: test_fast_dram_axi_rd_buffer
// PURPOSE
//  AXI read-data buffer placed directly upstream of the fast-DRAM SRAM AXI slave (sx* = network side, mx* = SRAM side).
//  Admits an AR only when the R FIFO has reserved room for the whole burst, so the SRAM R channel is never back-pressured.
//  Decouples a slow network rready from the SRAM. AW/W/B are wired straight through (combinational), no buffering.
// PARAMETERS
//  BW_ADDR     32   address width
//  BW_DATA     128  data width
//  BW_AXI_TID  4    AXI ID width
//  DEPTH       32   R FIFO entries; power of 2, >=2
//  BW_CNT      6    reservation/occupancy counter width = log2(DEPTH)+1
// PORTS
//  clk             in   1         clock
//  rst             in   1         synchronous active-high reset
//  sxar{id,addr,len,size,burst,valid}  in   AXI widths  AR request from network
//  sxarready       out  1         AR accept to network
//  mxar{id,addr,len,size,burst,valid}  out  AXI widths  AR request to SRAM slave
//  mxarready       in   1         AR accept from SRAM slave
//  mxr{id,data,resp,last,valid}        in   AXI widths  R beat from SRAM slave
//  mxrready        out  1         R accept to SRAM slave
//  sxr{id,data,resp,last,valid}        out  AXI widths  R beat to network
//  sxrready        in   1         R accept from network
//  sxaw*/sxw*/sxb* <-> mxaw*/mxw*/mxb*  mixed  AXI widths  write channels, pure pass-through
//  occupancy       out  BW_CNT    current FIFO entry count
//  overflow_err    out  1         sticky: R beat arrived with FIFO full
// BEHAVIOUR
//  Reset (rst=1 at posedge): FIFO empty, rd/wr ptrs=0, reserved=0, occupancy=0, overflow_err=0;
//   outputs: sxrvalid=0, sxarready=0 and mxarvalid=0 while rst=1, mxrready=1. Reset mid-burst drops all in-flight data.
//  Reservation: beats = len+1 (BW_CNT+1-bit arithmetic, no truncation).
//   admit = (reserved + beats <= DEPTH) || (reserved==0).
//   mxarvalid = sxarvalid & admit; sxarready = mxarready & admit; AR payload passes combinationally.
//   On AR handshake reserved += beats; on sxr handshake reserved -= 1; both same cycle -> net beats-1.
//   A burst with beats>DEPTH is admitted only when reserved==0; reserved saturates at 2^(BW_CNT+1)-1 and
//   its flow is governed by mxrready.
//  R path: mxrready = !full. Push on mxrvalid&mxrready of {id,data,resp,last}. sxrvalid = !empty, head driven from registered FIFO storage.
//   Pop on sxrvalid&sxrready. Latency mx->sx = 1 cycle (beat pushed at edge N visible at sx after edge N).
//   Full with simultaneous pop: mxrready stays 0 that cycle (no bypass). Empty: push and pop never coincide on same entry.
//   Throughput 1 beat/cycle when sxrready=1. Order preserved; no ID reordering.
//  Pointers wrap modulo DEPTH; full = (count==DEPTH), empty = (count==0).
//  overflow_err set when mxrvalid=1 & full (only reachable for beats>DEPTH bursts or a misbehaving slave); cleared only by rst.
//  Write channels: every mx/sx write signal equals its peer combinationally, including during reset.
// TESTING
//  1) Reset: hold rst 2 cycles with sxarvalid=1 -> sxarready=0, sxrvalid=0, occupancy=0, overflow_err=0.
//  2) Single AR len=3, sxrready=1 -> 4 beats on sx, each 1 cycle after mx, last on beat 4, reserved back to 0.
//  3) DEPTH=32: AR len=15 then len=15 accepted, third AR len=0 held (sxarready=0) until first sx pop occurs.
//  4) sxrready=0 for 40 cycles over len=31 burst -> occupancy reaches 32, mxrready=0 at full, no beat lost, order intact.
//  5) Same-cycle AR(len=7) accept and sx pop at reserved=10 -> reserved=17 next cycle.
//  6) AR len=63 with reserved=0 and sxrready=0 -> admitted, mxrready drops at 32 entries, overflow_err stays 0; AW/W/B echo check.

Source files
------------

// File: rtl/test_fast_dram_axi_rd_buffer.sv
// rtl/test_fast_dram_axi_rd_buffer.sv - AXI read-data buffer with burst reservation ahead of the fast-DRAM SRAM slave
// AW/W/B are combinational pass-through; AR is admitted only once the R FIFO has room for the whole burst.
module test_fast_dram_axi_rd_buffer #(
  parameter int BW_ADDR    = 32,
  parameter int BW_DATA    = 128,
  parameter int BW_AXI_TID = 4,
  parameter int DEPTH      = 32,
  parameter int BW_CNT     = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  // AR from network
  input  logic [BW_AXI_TID-1:0] sxarid,
  input  logic [BW_ADDR-1:0]    sxaraddr,
  input  logic [7:0]            sxarlen,
  input  logic [2:0]            sxarsize,
  input  logic [1:0]            sxarburst,
  input  logic                  sxarvalid,
  output logic                  sxarready,
  // AR to SRAM slave
  output logic [BW_AXI_TID-1:0] mxarid,
  output logic [BW_ADDR-1:0]    mxaraddr,
  output logic [7:0]            mxarlen,
  output logic [2:0]            mxarsize,
  output logic [1:0]            mxarburst,
  output logic                  mxarvalid,
  input  logic                  mxarready,
  // R from SRAM slave
  input  logic [BW_AXI_TID-1:0] mxrid,
  input  logic [BW_DATA-1:0]    mxrdata,
  input  logic [1:0]            mxrresp,
  input  logic                  mxrlast,
  input  logic                  mxrvalid,
  output logic                  mxrready,
  // R to network
  output logic [BW_AXI_TID-1:0] sxrid,
  output logic [BW_DATA-1:0]    sxrdata,
  output logic [1:0]            sxrresp,
  output logic                  sxrlast,
  output logic                  sxrvalid,
  input  logic                  sxrready,
  // AW pass-through
  input  logic [BW_AXI_TID-1:0] sxawid,
  input  logic [BW_ADDR-1:0]    sxawaddr,
  input  logic [7:0]            sxawlen,
  input  logic [2:0]            sxawsize,
  input  logic [1:0]            sxawburst,
  input  logic                  sxawvalid,
  output logic                  sxawready,
  output logic [BW_AXI_TID-1:0] mxawid,
  output logic [BW_ADDR-1:0]    mxawaddr,
  output logic [7:0]            mxawlen,
  output logic [2:0]            mxawsize,
  output logic [1:0]            mxawburst,
  output logic                  mxawvalid,
  input  logic                  mxawready,
  // W pass-through
  input  logic [BW_DATA-1:0]    sxwdata,
  input  logic [BW_DATA/8-1:0]  sxwstrb,
  input  logic                  sxwlast,
  input  logic                  sxwvalid,
  output logic                  sxwready,
  output logic [BW_DATA-1:0]    mxwdata,
  output logic [BW_DATA/8-1:0]  mxwstrb,
  output logic                  mxwlast,
  output logic                  mxwvalid,
  input  logic                  mxwready,
  // B pass-through
  input  logic [BW_AXI_TID-1:0] mxbid,
  input  logic [1:0]            mxbresp,
  input  logic                  mxbvalid,
  output logic                  mxbready,
  output logic [BW_AXI_TID-1:0] sxbid,
  output logic [1:0]            sxbresp,
  output logic                  sxbvalid,
  input  logic                  sxbready,
  // status
  output logic [BW_CNT-1:0]     occupancy,
  output logic                  overflow_err
);

  localparam int BW_PTR   = $clog2(DEPTH);
  localparam int BW_RES   = BW_CNT + 1;
  localparam int BW_SUM   = BW_RES + 9;
  localparam int BW_ENTRY = BW_AXI_TID + BW_DATA + 3;
  localparam logic [BW_CNT-1:0] CNT_FULL  = BW_CNT'(DEPTH);
  localparam logic [BW_SUM-1:0] SUM_DEPTH = BW_SUM'(DEPTH);
  localparam logic [BW_SUM-1:0] RES_MAX   = BW_SUM'((1 << BW_RES) - 1);

  logic [BW_ENTRY-1:0] mem [DEPTH];
  logic [BW_PTR-1:0]   wr_ptr, rd_ptr;
  logic [BW_CNT-1:0]   count;
  logic [BW_RES-1:0]   reserved;
  logic                full, empty, push, pop, admit, ar_hs;
  logic [BW_SUM-1:0]   beats, res_sum, res_next;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

  // Sum is kept wide so a 256-beat burst never wraps the admission compare.
  assign beats   = BW_SUM'(sxarlen) + BW_SUM'(1);
  assign res_sum = BW_SUM'(reserved) + beats;
  assign admit   = (res_sum <= SUM_DEPTH) || (reserved == '0);

  assign mxarid    = sxarid;
  assign mxaraddr  = sxaraddr;
  assign mxarlen   = sxarlen;
  assign mxarsize  = sxarsize;
  assign mxarburst = sxarburst;
  assign mxarvalid = sxarvalid & admit & ~rst;
  assign sxarready = mxarready & admit & ~rst;
  assign ar_hs     = mxarvalid & mxarready;

  assign mxrready = ~full | rst;
  assign sxrvalid = ~empty & ~rst;
  assign push     = mxrvalid & ~full & ~rst;
  assign pop      = ~empty & sxrready & ~rst;
  assign {sxrid, sxrdata, sxrresp, sxrlast} = mem[rd_ptr];
  assign occupancy = count;

  always_comb begin
    res_next = BW_SUM'(reserved);
    if (ar_hs) res_next = res_sum;
    if (pop && (res_next != '0)) res_next = res_next - BW_SUM'(1);
    if (res_next > RES_MAX) res_next = RES_MAX;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {mxrid, mxrdata, mxrresp, mxrlast};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      reserved     <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + BW_PTR'(1);
      if (pop)  rd_ptr <= rd_ptr + BW_PTR'(1);
      count    <= count + BW_CNT'(push) - BW_CNT'(pop);
      reserved <= res_next[BW_RES-1:0];
      if (mxrvalid && full) overflow_err <= 1'b1;
    end
  end

  assign mxawid    = sxawid;
  assign mxawaddr  = sxawaddr;
  assign mxawlen   = sxawlen;
  assign mxawsize  = sxawsize;
  assign mxawburst = sxawburst;
  assign mxawvalid = sxawvalid;
  assign sxawready = mxawready;
  assign mxwdata   = sxwdata;
  assign mxwstrb   = sxwstrb;
  assign mxwlast   = sxwlast;
  assign mxwvalid  = sxwvalid;
  assign sxwready  = mxwready;
  assign sxbid     = mxbid;
  assign sxbresp   = mxbresp;
  assign sxbvalid  = mxbvalid;
  assign mxbready  = sxbready;

endmodule

// File: tb/tb_test_fast_dram_axi_rd_buffer.sv
// tb/tb_test_fast_dram_axi_rd_buffer.sv - self-checking bench for the AXI read-data buffer
// Queue-based model of the FIFO and burst reservations plus a table of write-channel vectors.
module tb_test_fast_dram_axi_rd_buffer;
  localparam int BW_ADDR = 32, BW_DATA = 128, TID = 4, DEPTH = 32, BW_CNT = 6;

  logic clk = 1'b0;
  logic rst;
  logic [TID-1:0] sxarid, mxarid, mxrid, sxrid, sxawid, mxawid, mxbid, sxbid;
  logic [BW_ADDR-1:0] sxaraddr, mxaraddr, sxawaddr, mxawaddr;
  logic [7:0] sxarlen, mxarlen, sxawlen, mxawlen;
  logic [2:0] sxarsize, mxarsize, sxawsize, mxawsize;
  logic [1:0] sxarburst, mxarburst, sxawburst, mxawburst, mxrresp, sxrresp, mxbresp, sxbresp;
  logic sxarvalid, sxarready, mxarvalid, mxarready;
  logic [BW_DATA-1:0] mxrdata, sxrdata, sxwdata, mxwdata;
  logic [BW_DATA/8-1:0] sxwstrb, mxwstrb;
  logic mxrlast, mxrvalid, mxrready, sxrlast, sxrvalid, sxrready;
  logic sxawvalid, sxawready, mxawvalid, mxawready;
  logic sxwlast, sxwvalid, sxwready, mxwlast, mxwvalid, mxwready;
  logic mxbvalid, mxbready, sxbvalid, sxbready;
  logic [BW_CNT-1:0] occupancy;
  logic overflow_err;

  always #5 clk = ~clk;

  test_fast_dram_axi_rd_buffer #(.BW_ADDR(BW_ADDR), .BW_DATA(BW_DATA), .BW_AXI_TID(TID),
                                 .DEPTH(DEPTH), .BW_CNT(BW_CNT)) dut (
    .clk(clk), .rst(rst),
    .sxarid(sxarid), .sxaraddr(sxaraddr), .sxarlen(sxarlen), .sxarsize(sxarsize),
    .sxarburst(sxarburst), .sxarvalid(sxarvalid), .sxarready(sxarready),
    .mxarid(mxarid), .mxaraddr(mxaraddr), .mxarlen(mxarlen), .mxarsize(mxarsize),
    .mxarburst(mxarburst), .mxarvalid(mxarvalid), .mxarready(mxarready),
    .mxrid(mxrid), .mxrdata(mxrdata), .mxrresp(mxrresp), .mxrlast(mxrlast),
    .mxrvalid(mxrvalid), .mxrready(mxrready),
    .sxrid(sxrid), .sxrdata(sxrdata), .sxrresp(sxrresp), .sxrlast(sxrlast),
    .sxrvalid(sxrvalid), .sxrready(sxrready),
    .sxawid(sxawid), .sxawaddr(sxawaddr), .sxawlen(sxawlen), .sxawsize(sxawsize),
    .sxawburst(sxawburst), .sxawvalid(sxawvalid), .sxawready(sxawready),
    .mxawid(mxawid), .mxawaddr(mxawaddr), .mxawlen(mxawlen), .mxawsize(mxawsize),
    .mxawburst(mxawburst), .mxawvalid(mxawvalid), .mxawready(mxawready),
    .sxwdata(sxwdata), .sxwstrb(sxwstrb), .sxwlast(sxwlast), .sxwvalid(sxwvalid),
    .sxwready(sxwready),
    .mxwdata(mxwdata), .mxwstrb(mxwstrb), .mxwlast(mxwlast), .mxwvalid(mxwvalid),
    .mxwready(mxwready),
    .mxbid(mxbid), .mxbresp(mxbresp), .mxbvalid(mxbvalid), .mxbready(mxbready),
    .sxbid(sxbid), .sxbresp(sxbresp), .sxbvalid(sxbvalid), .sxbready(sxbready),
    .occupancy(occupancy), .overflow_err(overflow_err)
  );

  typedef struct {
    logic [TID-1:0]     id;
    logic [BW_DATA-1:0] data;
    logic [1:0]         resp;
    logic               last;
  } beat_t;

  typedef struct {
    logic               rst_v;
    logic [BW_ADDR-1:0] awaddr;
    logic               awvalid;
    logic [BW_DATA-1:0] wdata;
    logic               wvalid;
    logic [1:0]         bresp;
    logic               bvalid;
    logic               awready_m;
    logic               wready_m;
    logic               bready_s;
    logic [BW_ADDR-1:0] exp_awaddr;
    logic               exp_awvalid;
    logic [BW_DATA-1:0] exp_wdata;
    logic               exp_wvalid;
    logic [1:0]         exp_bresp;
    logic               exp_bvalid;
    logic               exp_awready;
    logic               exp_wready;
    logic               exp_bready;
  } wr_vec_t;

  beat_t fifo_q[$];
  beat_t slave_q[$];
  int    res_m;
  bit    ovf_m;
  int    slave_stall;
  bit    force_ovf;
  int    pop_cnt, last_at;
  int    n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [BW_DATA-1:0] act, input logic [BW_DATA-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  function automatic logic [BW_DATA-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // The SRAM slave only offers a beat while the buffer can take it, unless force_ovf.
  task automatic drive_slave();
    if (slave_q.size() != 0 &&
        (force_ovf || (fifo_q.size() < DEPTH && $urandom_range(0, 99) >= slave_stall))) begin
      mxrvalid = 1'b1;
      mxrid    = slave_q[0].id;
      mxrdata  = slave_q[0].data;
      mxrresp  = slave_q[0].resp;
      mxrlast  = slave_q[0].last;
    end else begin
      mxrvalid = 1'b0;
    end
  endtask

  // One clock: entered just after a negedge with inputs set, leaves just after the next negedge.
  task automatic cycle();
    int beats;
    bit adm, ar_hs, push, pop, ovf_set;
    beat_t b;
    #1;
    beats = int'(sxarlen) + 1;
    adm   = (res_m + beats <= DEPTH) || (res_m == 0);
    check("mxarvalid", mxarvalid, sxarvalid & adm);
    check("sxarready", sxarready, mxarready & adm);
    check("mxaraddr", mxaraddr, sxaraddr);
    check("mxarid", mxarid, sxarid);
    check("mxrready", mxrready, fifo_q.size() < DEPTH);
    check("sxrvalid", sxrvalid, fifo_q.size() != 0);
    check("occupancy", occupancy, fifo_q.size());
    check("overflow_err", overflow_err, ovf_m);
    if (fifo_q.size() != 0) begin
      check("sxrid", sxrid, fifo_q[0].id);
      check("sxrdata", sxrdata, fifo_q[0].data);
      check("sxrresp", sxrresp, fifo_q[0].resp);
      check("sxrlast", sxrlast, fifo_q[0].last);
    end
    ar_hs   = sxarvalid && adm && mxarready;
    push    = mxrvalid && (fifo_q.size() < DEPTH);
    pop     = (fifo_q.size() != 0) && sxrready;
    ovf_set = mxrvalid && (fifo_q.size() == DEPTH);
    if (pop && sxrlast === 1'b1) last_at = pop_cnt + 1;
    @(posedge clk);
    if (pop) begin
      void'(fifo_q.pop_front());
      pop_cnt++;
    end
    if (push) fifo_q.push_back(slave_q.pop_front());
    if (ovf_set) ovf_m = 1'b1;
    res_m = res_m + (ar_hs ? beats : 0);
    if (pop && res_m > 0) res_m--;
    if (res_m > 127) res_m = 127;
    if (ar_hs) begin
      for (int i = 0; i < beats; i++) begin
        b.id   = sxarid;
        b.data = rand128();
        b.resp = 2'($urandom_range(0, 3));
        b.last = (i == beats - 1);
        slave_q.push_back(b);
      end
    end
    @(negedge clk);
    if (ar_hs) sxarvalid = 1'b0;
    drive_slave();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sxarvalid = 1'b1;
    sxarlen = 8'd0;
    mxrvalid = 1'b0;
    sxrready = 1'b0;
    repeat (2) begin
      #1;
      check("rst_sxarready", sxarready, 1'b0);
      check("rst_mxarvalid", mxarvalid, 1'b0);
      check("rst_sxrvalid", sxrvalid, 1'b0);
      check("rst_mxrready", mxrready, 1'b1);
      @(posedge clk);
      #1;
      check("rst_occupancy", occupancy, 0);
      check("rst_overflow", overflow_err, 1'b0);
      @(negedge clk);
    end
    rst = 1'b0;
    sxarvalid = 1'b0;
    fifo_q.delete();
    slave_q.delete();
    res_m = 0;
    ovf_m = 1'b0;
  endtask

  task automatic set_ar(input int len);
    sxarvalid = 1'b1;
    sxarlen   = 8'(len);
    sxarid    = 4'($urandom);
    sxaraddr  = $urandom;
  endtask

  task automatic issue_ar(input int len, input int budget);
    set_ar(len);
    for (int i = 0; i < budget && sxarvalid; i++) cycle();
    if (sxarvalid) begin
      timeout("ar_accept");
      sxarvalid = 1'b0;
    end
  endtask

  task automatic drain(input int budget);
    sxrready  = 1'b1;
    mxarready = 1'b1;
    for (int i = 0; i < budget && (sxarvalid || fifo_q.size() != 0 || slave_q.size() != 0); i++) cycle();
    if (sxarvalid || fifo_q.size() != 0 || slave_q.size() != 0) timeout("drain");
  endtask

  wr_vec_t wv[4];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    sxarid = '0; sxaraddr = '0; sxarlen = '0; sxarsize = 3'd4; sxarburst = 2'b01; sxarvalid = 1'b0;
    mxarready = 1'b1;
    mxrid = '0; mxrdata = '0; mxrresp = '0; mxrlast = 1'b0; mxrvalid = 1'b0;
    sxrready = 1'b0;
    sxawid = 4'h3; sxawaddr = '0; sxawlen = 8'd7; sxawsize = 3'd4; sxawburst = 2'b01; sxawvalid = 1'b0;
    mxawready = 1'b0;
    sxwdata = '0; sxwstrb = '1; sxwlast = 1'b0; sxwvalid = 1'b0; mxwready = 1'b0;
    mxbid = 4'h3; mxbresp = '0; mxbvalid = 1'b0; sxbready = 1'b0;
    slave_stall = 0; force_ovf = 1'b0; res_m = 0; ovf_m = 1'b0;

    wv[0] = '{1'b0, 32'h1000_0040, 1'b1, 128'h0123_4567_89ab_cdef_0011_2233_4455_6677, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1,
              32'h1000_0040, 1'b1, 128'h0123_4567_89ab_cdef_0011_2233_4455_6677, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1};
    wv[1] = '{1'b0, 32'hffff_fff0, 1'b0, 128'hffff_0000_ffff_0000_ffff_0000_ffff_0000, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0,
              32'hffff_fff0, 1'b0, 128'hffff_0000_ffff_0000_ffff_0000_ffff_0000, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0};
    wv[2] = '{1'b1, 32'h0000_0000, 1'b1, 128'h0, 1'b1, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1,
              32'h0000_0000, 1'b1, 128'h0, 1'b1, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1};
    wv[3] = '{1'b1, 32'h8000_1234, 1'b0, 128'hdead_beef_0000_0000_0000_0000_cafe_f00d, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0,
              32'h8000_1234, 1'b0, 128'hdead_beef_0000_0000_0000_0000_cafe_f00d, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0};

    @(negedge clk);
    do_reset();

    // single 4-beat burst, network always ready
    pop_cnt = 0; last_at = 0;
    sxrready = 1'b1;
    issue_ar(3, 10);
    drain(40);
    check("t2_beats", pop_cnt, 4);
    check("t2_last_on_beat4", last_at, 4);
    mxarready = 1'b0; set_ar(40); #1;
    check("t2_reserved_zero", mxarvalid, 1'b1);
    sxarvalid = 1'b0; mxarready = 1'b1;

    // two 16-beat bursts fill the reservation, third waits for the first pop
    sxrready = 1'b0;
    issue_ar(15, 5);
    issue_ar(15, 5);
    set_ar(0);
    repeat (6) begin
      #1 check("t3_ar_held", sxarready, 1'b0);
      cycle();
    end
    sxrready = 1'b1;
    for (int i = 0; i < 20 && sxarvalid; i++) cycle();
    if (sxarvalid) timeout("t3_ar_release");
    drain(200);

    // full-depth burst with network stalled
    sxrready = 1'b0;
    issue_ar(31, 5);
    repeat (40) cycle();
    check("t4_occupancy_full", occupancy, 32);
    check("t4_mxrready_full", mxrready, 1'b0);
    drain(200);

    // AR accept coincides with a pop at reserved=10
    sxrready = 1'b0;
    issue_ar(9, 5);
    for (int i = 0; i < 20 && fifo_q.size() == 0; i++) cycle();
    if (fifo_q.size() == 0) timeout("t5_fill");
    sxrready = 1'b1; mxarready = 1'b1; set_ar(7);
    cycle();
    check("t5_ar_taken", sxarvalid, 1'b0);
    sxrready = 1'b0; mxarready = 1'b0;
    set_ar(14); #1;
    check("t5_len14_admit", mxarvalid, 1'b1);
    sxarlen = 8'd15; #1;
    check("t5_len15_block", mxarvalid, 1'b0);
    sxarvalid = 1'b0;
    drain(200);

    // oversize burst admitted from zero reservation, governed by mxrready
    sxrready = 1'b0;
    issue_ar(63, 5);
    repeat (80) cycle();
    check("t6_occupancy", occupancy, 32);
    check("t6_mxrready", mxrready, 1'b0);
    check("t6_no_overflow", overflow_err, 1'b0);

    // write channels echo combinationally, including while rst is high
    for (int i = 0; i < 4; i++) begin
      rst = wv[i].rst_v;
      sxawaddr = wv[i].awaddr; sxawvalid = wv[i].awvalid;
      sxwdata = wv[i].wdata; sxwvalid = wv[i].wvalid;
      mxbresp = wv[i].bresp; mxbvalid = wv[i].bvalid;
      mxawready = wv[i].awready_m; mxwready = wv[i].wready_m; sxbready = wv[i].bready_s;
      #0.5;
      check("wr_mxawaddr", mxawaddr, wv[i].exp_awaddr);
      check("wr_mxawvalid", mxawvalid, wv[i].exp_awvalid);
      check("wr_mxwdata", mxwdata, wv[i].exp_wdata);
      check("wr_mxwvalid", mxwvalid, wv[i].exp_wvalid);
      check("wr_sxbresp", sxbresp, wv[i].exp_bresp);
      check("wr_sxbvalid", sxbvalid, wv[i].exp_bvalid);
      check("wr_sxawready", sxawready, wv[i].exp_awready);
      check("wr_sxwready", sxwready, wv[i].exp_wready);
      check("wr_mxbready", mxbready, wv[i].exp_bready);
    end
    rst = 1'b0;
    check("wr_sxbid", sxbid, 4'h3);
    check("wr_mxawlen", mxawlen, 8'd7);

    // misbehaving slave pushes into a full buffer: sticky error until reset
    @(negedge clk);
    force_ovf = 1'b1;
    drive_slave();
    cycle();
    force_ovf = 1'b0;
    mxrvalid = 1'b0;
    cycle();
    check("t6_overflow_set", overflow_err, 1'b1);
    cycle();
    check("t6_overflow_sticky", overflow_err, 1'b1);
    do_reset();

    // randomized traffic
    slave_stall = 25;
    for (int n = 0; n < 1500; n++) begin
      if (!sxarvalid && $urandom_range(0, 3) == 0)
        set_ar(($urandom_range(0, 9) == 0) ? $urandom_range(33, 40) : $urandom_range(0, 15));
      sxrready  = ($urandom_range(0, 2) != 0);
      mxarready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    slave_stall = 0;
    drain(2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
